// File: rtl/demux_deser_if.sv
// demux_deser_if: serial input, framing and word output port bundle of the deserializer
interface demux_deser_if #(parameter int SEL_W = 3);
  logic                  data_i;
  logic                  valid_i;
  logic                  sync_i;
  logic                  ready_i;
  logic [SEL_W-1:0]      sel_o;
  logic [(2**SEL_W)-1:0] data_o;
  logic                  valid_o;
  logic                  overrun_o;
  modport master (output data_i, valid_i, sync_i, ready_i, input sel_o, data_o, valid_o, overrun_o);
  modport slave (input data_i, valid_i, sync_i, ready_i, output sel_o, data_o, valid_o, overrun_o);
endinterface

// File: rtl/demux_deser.sv
// demux_deser: steers a serial bit stream into word slots and buffers each completed word
module demux_deser #(parameter int SEL_W = 3) (
  input logic         clk,
  input logic         rst_n,
  demux_deser_if.slave bus
);
  localparam int W = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST = '1;
  logic [SEL_W-1:0] r_slot;
  logic [W-1:0]     r_asm;
  logic [W-1:0]     r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_done;
  logic             w_hs;
  logic [W-1:0]     w_word;
  assign w_done = bus.valid_i && !bus.sync_i && r_slot == LAST;
  assign w_hs   = r_valid && bus.ready_i;
  assign w_word = {bus.data_i, r_asm[W-2:0]};
  assign bus.sel_o     = r_slot;
  assign bus.data_o    = r_data;
  assign bus.valid_o   = r_valid;
  assign bus.overrun_o = r_overrun;
  // slot assembly plus one-word output buffer; completion with a busy, unconsumed buffer drops the word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_slot    <= '0;
      r_asm     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.sync_i) begin
        r_slot <= bus.valid_i ? SEL_W'(1) : '0;
        r_asm  <= bus.valid_i ? W'(bus.data_i) : '0;
      end else if (bus.valid_i) begin
        r_slot         <= r_slot + SEL_W'(1);
        r_asm[r_slot]  <= bus.data_i;
      end
      if (w_hs) r_valid <= 1'b0;
      if (w_done && (!r_valid || w_hs)) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_done) r_overrun <= 1'b1;
    end
endmodule

// File: tb/tb_demux_deser.sv
// tb_demux_deser: directed-vector checks of slot stepping, framing, buffering and overrun
module tb_demux_deser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  demux_deser_if #(.SEL_W(3)) bus();
  demux_deser #(.SEL_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic send_bit(input logic d, input logic v, input logic s);
    @(negedge clk);
    bus.data_i = d;
    bus.valid_i = v;
    bus.sync_i = s;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.sync_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b1, 1'b0);
  endtask

  task automatic test_single;
    logic [7:0] b = 8'h9A;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.sel_o !== 3'(i)) begin failures++; $display("FAIL single_sel%0d got %0d exp %0d", i, bus.sel_o, i); end
      send_bit(b[i], 1'b1, 1'b0);
    end
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h9A) begin failures++; $display("FAIL single_word got v=%b d=%h exp v=1 d=9a", bus.valid_o, bus.data_o); end
    checks++;
    if (bus.sel_o !== 3'd0) begin failures++; $display("FAIL single_wrap got %0d exp 0", bus.sel_o); end
    send_bit(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL single_consumed got v=%b exp 0", bus.valid_o); end
  endtask

  task automatic test_gapped;
    logic [7:0] b = 8'h9A;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5 || i == 7) begin
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.sel_o !== 3'(i)) begin failures++; $display("FAIL gap_hold%0d got %0d exp %0d", i, bus.sel_o, i); end
      end
      send_bit(b[i], 1'b1, 1'b0);
    end
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h9A) begin failures++; $display("FAIL gap_word got v=%b d=%h exp v=1 d=9a", bus.valid_o, bus.data_o); end
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync;
    logic [7:0] b = 8'hC3;
    logic [7:0] c = 8'h3C;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.sel_o !== 3'd0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL sync_realign got sel=%0d v=%b exp sel=0 v=0", bus.sel_o, bus.valid_o); end
    for (int i = 0; i < 7; i++) send_bit(b[i], 1'b1, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL sync_no_partial got v=%b exp 0", bus.valid_o); end
    send_bit(b[7], 1'b1, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'hC3) begin failures++; $display("FAIL sync_word got v=%b d=%h exp v=1 d=c3", bus.valid_o, bus.data_o); end
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(c[0], 1'b1, 1'b1);
    checks++;
    if (bus.sel_o !== 3'd1) begin failures++; $display("FAIL sync_valid_sel got %0d exp 1", bus.sel_o); end
    for (int i = 1; i < 8; i++) send_bit(c[i], 1'b1, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h3C) begin failures++; $display("FAIL sync_valid_word got v=%b d=%h exp v=1 d=3c", bus.valid_o, bus.data_o); end
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    bus.ready_i = 1'b0;
    send_byte(8'h55);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h55 || bus.overrun_o !== 1'b0) begin failures++; $display("FAIL bp_first got v=%b d=%h ov=%b exp v=1 d=55 ov=0", bus.valid_o, bus.data_o, bus.overrun_o); end
    send_byte(8'hAA);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h55 || bus.overrun_o !== 1'b1) begin failures++; $display("FAIL bp_overrun got v=%b d=%h ov=%b exp v=1 d=55 ov=1", bus.valid_o, bus.data_o, bus.overrun_o); end
    bus.ready_i = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.overrun_o !== 1'b1) begin failures++; $display("FAIL bp_drain got v=%b ov=%b exp v=0 ov=1", bus.valid_o, bus.overrun_o); end
  endtask

  task automatic test_reset;
    bus.ready_i = 1'b0;
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sel_o !== 3'd0 || bus.data_o !== 8'h00 || bus.valid_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got sel=%0d d=%h v=%b ov=%b exp all 0", bus.sel_o, bus.data_o, bus.valid_o, bus.overrun_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.sel_o !== 3'd0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_release got sel=%0d v=%b exp sel=0 v=0", bus.sel_o, bus.valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b = 8'h0F;
    bus.ready_i = 1'b0;
    send_byte(8'h33);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h33) begin failures++; $display("FAIL b2b_first got v=%b d=%h exp v=1 d=33", bus.valid_o, bus.data_o); end
    for (int i = 0; i < 7; i++) send_bit(b[i], 1'b1, 1'b0);
    checks++;
    if (bus.data_o !== 8'h33) begin failures++; $display("FAIL b2b_stable got %h exp 33", bus.data_o); end
    bus.ready_i = 1'b1;
    send_bit(b[7], 1'b1, 1'b0);
    bus.ready_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h0F || bus.overrun_o !== 1'b0) begin failures++; $display("FAIL b2b_load got v=%b d=%h ov=%b exp v=1 d=0f ov=0", bus.valid_o, bus.data_o, bus.overrun_o); end
    bus.ready_i = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%b exp 0", bus.valid_o); end
  endtask

  initial begin
    bus.data_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.sync_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if (bus.sel_o !== 3'd0 || bus.data_o !== 8'h00 || bus.valid_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got sel=%0d d=%h v=%b ov=%b exp all 0", bus.sel_o, bus.data_o, bus.valid_o, bus.overrun_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_single;
    test_gapped;
    test_sync;
    test_backpressure;
    test_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
